// File: rtl/vga_test_pattern_gen.sv
// VGA test pattern generator: derives its own pixel counters from incoming syncs and drives a
// registered colour pattern two cycles behind the syncs. Define VGA_TPG_MOVING_BOX_EN to build pattern 7.
module vga_test_pattern_gen #(
  parameter int VIDEO_WIDTH  = 3,
  parameter int TOTAL_COLS   = 800,
  parameter int TOTAL_ROWS   = 525,
  parameter int ACTIVE_COLS  = 640,
  parameter int ACTIVE_ROWS  = 480,
  parameter int CHECKER_LOG2 = 5,
  parameter int RAMP_SHIFT   = 6,
  parameter int BOX_SIZE     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [2:0]             i_pattern,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [VIDEO_WIDTH-1:0] o_red_video,
  output logic [VIDEO_WIDTH-1:0] o_green_video,
  output logic [VIDEO_WIDTH-1:0] o_blue_video,
  output logic                   o_frame_start
);

  localparam int CW    = $clog2(TOTAL_COLS);
  localparam int RW    = $clog2(TOTAL_ROWS);
  localparam int BAR_W = ACTIVE_COLS / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [VIDEO_WIDTH-1:0] MAX = '1;

  logic          vsync_q;
  logic          fs;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [2:0]    pattern;
  logic          hsync_d1, vsync_d1, fs_d1;
  logic          line_end;

  assign fs       = i_vsync & ~vsync_q;
  assign line_end = (col == CW'(TOTAL_COLS - 1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vsync_q  <= 1'b0;
      col      <= '0;
      row      <= '0;
      bar_px   <= '0;
      bar_idx  <= '0;
      pattern  <= '0;
      hsync_d1 <= 1'b0;
      vsync_d1 <= 1'b0;
      fs_d1    <= 1'b0;
    end else begin
      vsync_q  <= i_vsync;
      hsync_d1 <= i_hsync;
      vsync_d1 <= i_vsync;
      fs_d1    <= fs;
      if (fs) begin
        col     <= '0;
        row     <= '0;
        pattern <= i_pattern;
      end else if (line_end) begin
        col <= '0;
        row <= (row == RW'(TOTAL_ROWS - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      // Bar counter tracks col so the bar index needs no divider.
      if (fs || line_end) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BW'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + BW'(1);
      end
    end
  end

`ifdef VGA_TPG_MOVING_BOX_EN
  localparam int BX_MAX = ACTIVE_COLS - BOX_SIZE;
  localparam int BY_MAX = ACTIVE_ROWS - BOX_SIZE;

  logic [CW-1:0] bx;
  logic [RW-1:0] by;
  logic          dx, dy;  // 1 = increasing
  logic [CW:0]   bx_end;
  logic [RW:0]   by_end;
  logic          in_box;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else if (fs) begin
      if (dx && bx == CW'(BX_MAX)) begin
        dx <= 1'b0;
        bx <= bx - CW'(1);
      end else if (!dx && bx == '0) begin
        dx <= 1'b1;
        bx <= bx + CW'(1);
      end else begin
        bx <= dx ? bx + CW'(1) : bx - CW'(1);
      end
      if (dy && by == RW'(BY_MAX)) begin
        dy <= 1'b0;
        by <= by - RW'(1);
      end else if (!dy && by == '0) begin
        dy <= 1'b1;
        by <= by + RW'(1);
      end else begin
        by <= dy ? by + RW'(1) : by - RW'(1);
      end
    end
  end

  assign bx_end = {1'b0, bx} + (CW+1)'(BOX_SIZE);
  assign by_end = {1'b0, by} + (RW+1)'(BOX_SIZE);
  assign in_box = (col >= bx) && ({1'b0, col} < bx_end) &&
                  (row >= by) && ({1'b0, row} < by_end);
`endif

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  logic                   active;
  logic [2:0]             bar_c;
  logic [VIDEO_WIDTH-1:0] ramp;
  logic [VIDEO_WIDTH-1:0] red_n, green_n, blue_n;

  assign active = (col < CW'(ACTIVE_COLS)) && (row < RW'(ACTIVE_ROWS));
  assign bar_c  = bar_rgb(bar_idx);
  assign ramp   = VIDEO_WIDTH'(col >> RAMP_SHIFT);

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    if (active) begin
      case (pattern)
        3'd1: red_n   = MAX;
        3'd2: green_n = MAX;
        3'd3: blue_n  = MAX;
        3'd4: if (col[CHECKER_LOG2] ^ row[CHECKER_LOG2]) begin
          red_n   = MAX;
          green_n = MAX;
          blue_n  = MAX;
        end
        3'd5: begin
          red_n   = {VIDEO_WIDTH{bar_c[2]}};
          green_n = {VIDEO_WIDTH{bar_c[1]}};
          blue_n  = {VIDEO_WIDTH{bar_c[0]}};
        end
        3'd6: begin
          red_n   = ramp;
          green_n = ramp;
          blue_n  = ramp;
        end
        3'd7: begin
`ifdef VGA_TPG_MOVING_BOX_EN
          blue_n = MAX;
          if (in_box) begin
            red_n   = MAX;
            green_n = MAX;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_frame_start <= 1'b0;
      o_red_video   <= '0;
      o_green_video <= '0;
      o_blue_video  <= '0;
    end else begin
      o_hsync       <= hsync_d1;
      o_vsync       <= vsync_d1;
      o_frame_start <= fs_d1;
      o_red_video   <= red_n;
      o_green_video <= green_n;
      o_blue_video  <= blue_n;
    end
  end

endmodule

// File: tb/tb_vga_test_pattern_gen.sv
// Scoreboard bench for vga_test_pattern_gen on a reduced 48x24 raster (32x16 active) so that the
// moving box bounces within a short run.
module tb_vga_test_pattern_gen;

  localparam int VW = 3, TC = 48, TR = 24, AC = 32, AR = 16, CL = 2, RS = 2, BS = 8;
  localparam int FRAME = TC * TR;

  logic          clk = 1'b0;
  logic          rst, hs, vs;
  logic [2:0]    pat;
  logic          o_hs, o_vs, o_fs;
  logic [VW-1:0] r, g, b;

  always #20 clk = ~clk;

  vga_test_pattern_gen #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .CHECKER_LOG2(CL), .RAMP_SHIFT(RS), .BOX_SIZE(BS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs), .i_vsync(vs), .i_pattern(pat),
    .o_hsync(o_hs), .o_vsync(o_vs), .o_red_video(r), .o_green_video(g), .o_blue_video(b),
    .o_frame_start(o_fs)
  );

  typedef struct {
    logic [11:0] v;  // {hsync, vsync, frame_start, r, g, b}
    int col, row, pat, frame;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;

  // Sync source, model state and drive controls.
  int hc = 10, vc = 20;
  int m_col, m_row, m_pat, m_frame, bx, by;
  bit m_prev_vs, dx, dy;
  bit rst_drv = 1'b1, rst_h1 = 1'b0, rst_h2 = 1'b0;
  int pat_sel = 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_col = 0; m_row = 0; m_pat = 0; m_frame = 0; m_prev_vs = 1'b0;
    bx = 0; by = 0; dx = 1'b1; dy = 1'b1;
  endfunction

  function automatic logic [8:0] model_rgb(int c, int rw, int p);
    logic [8:0] rgb;
    bit in_box;
    rgb = '0;
    in_box = (c >= bx) && (c < bx + BS) && (rw >= by) && (rw < by + BS);
    if (c < AC && rw < AR) begin
      case (p)
        1: rgb = 9'o700;
        2: rgb = 9'o070;
        3: rgb = 9'o007;
        4: rgb = (((c >> CL) ^ (rw >> CL)) & 1) != 0 ? 9'o777 : 9'o000;
        5: case (c / (AC / 8))
             0: rgb = 9'o777; 1: rgb = 9'o770; 2: rgb = 9'o077; 3: rgb = 9'o070;
             4: rgb = 9'o707; 5: rgb = 9'o700; 6: rgb = 9'o007; default: rgb = 9'o000;
           endcase
        6: begin
          rgb[8:6] = 3'((c >> RS) & 7);
          rgb[5:3] = rgb[8:6];
          rgb[2:0] = rgb[8:6];
        end
`ifdef VGA_TPG_MOVING_BOX_EN
        7: rgb = in_box ? 9'o777 : 9'o007;
`endif
        default: rgb = '0;
      endcase
    end
    return rgb;
  endfunction

  function automatic logic [8:0] box_exp(bit white);
`ifdef VGA_TPG_MOVING_BOX_EN
    return white ? 9'o777 : 9'o007;
`else
    return 9'o000;
`endif
  endfunction

  task automatic spot_checks(input exp_t e);
    logic [8:0] px;
    px = {r, g, b};
    if (e.pat == 4 && e.row == 0 && e.col == 3)  check("chk_3_0", px, 9'o000);
    if (e.pat == 4 && e.row == 0 && e.col == 4)  check("chk_4_0", px, 9'o777);
    if (e.pat == 4 && e.row == 4 && e.col == 4)  check("chk_4_4", px, 9'o000);
    if (e.pat == 4 && e.row == 2 && e.col == 32) check("chk_blank", px, 9'o000);
    if (e.pat == 5 && e.row == 1 && e.col == 0)  check("bar_white", px, 9'o777);
    if (e.pat == 5 && e.row == 1 && e.col == 4)  check("bar_yellow", px, 9'o770);
    if (e.pat == 5 && e.row == 1 && e.col == 8)  check("bar_cyan", px, 9'o077);
    if (e.pat == 5 && e.row == 1 && e.col == 28) check("bar_black", px, 9'o000);
    if (e.pat == 7 && e.frame == 1 && e.row == 1 && e.col == 1)  check("box_f1_in", px, box_exp(1));
    if (e.pat == 7 && e.frame == 1 && e.row == 1 && e.col == 0)  check("box_f1_out", px, box_exp(0));
    if (e.pat == 7 && e.frame == 24 && e.row == 8 && e.col == 24) check("box_f24_in", px, box_exp(1));
    if (e.pat == 7 && e.frame == 24 && e.row == 8 && e.col == 23) check("box_f24_out", px, box_exp(0));
    if (e.pat == 7 && e.frame == 25 && e.row == 7 && e.col == 23) check("box_f25_in", px, box_exp(1));
    if (e.pat == 7 && e.frame == 25 && e.row == 7 && e.col == 31) check("box_f25_out", px, box_exp(0));
    if (e.col == 0 && e.row == 0 && e.frame > 0) check("fs_pulse", {31'd0, o_fs}, 32'd1);
  endtask

  // One clock: compare what the DUT shows now, then drive the next inputs and predict their result.
  task automatic step();
    exp_t e;
    bit   fs;
    @(posedge clk);
    #1;
    if (rst_h1 || rst_h2) begin
      check("rst_zero", {o_hs, o_vs, o_fs, r, g, b}, 32'd0);
    end else if (q.size() >= 2) begin
      e = q.pop_front();
      check($sformatf("px f%0d r%0d c%0d", e.frame, e.row, e.col), {o_hs, o_vs, o_fs, r, g, b}, e.v);
      spot_checks(e);
    end
    hs  = (hc < AC);
    vs  = (vc < AR);
    pat = 3'(pat_sel);
    rst = rst_drv;
    hc++;
    if (hc == TC) begin
      hc = 0;
      vc = (vc == TR - 1) ? 0 : vc + 1;
    end
    rst_h2 = rst_h1;
    rst_h1 = rst_drv;
    if (rst_drv) begin
      q.delete();
      model_reset();
    end else begin
      fs = vs && !m_prev_vs;
      m_prev_vs = vs;
      if (fs) begin
        m_col = 0; m_row = 0; m_pat = pat_sel; m_frame++;
        if (dx) begin if (bx == AC - BS) begin dx = 0; bx--; end else bx++; end
        else    begin if (bx == 0)       begin dx = 1; bx++; end else bx--; end
        if (dy) begin if (by == AR - BS) begin dy = 0; by--; end else by++; end
        else    begin if (by == 0)       begin dy = 1; by++; end else by--; end
      end else begin
        m_col++;
        if (m_col == TC) begin
          m_col = 0;
          m_row = (m_row == TR - 1) ? 0 : m_row + 1;
        end
      end
      e.v     = {hs, vs, fs, model_rgb(m_col, m_row, m_pat)};
      e.col   = m_col;
      e.row   = m_row;
      e.pat   = m_pat;
      e.frame = m_frame;
      q.push_back(e);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; pat = 3'd0;
    model_reset();
    repeat (3) step();
    rst_drv = 1'b0;
    pat_sel = 1; repeat (FRAME + 300) step();
    pat_sel = 4; repeat (FRAME) step();
    pat_sel = 5; repeat (FRAME) step();
    pat_sel = 6; repeat (FRAME) step();
    pat_sel = 2; repeat (FRAME) step();
    // Mid-frame switch to pattern 3 must only take effect at the next frame start.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      found = (m_row == 8 && m_col == 5);
    end
    check("reach_row8", {31'd0, found}, 32'd1);
    pat_sel = 3; repeat (FRAME + 100) step();
    // Reset in the middle of a visible line.
    found = 1'b0;
    for (int i = 0; i < 2 * TC && !found; i++) begin
      step();
      found = (m_col == 20 && m_row < AR);
    end
    check("reach_midline", {31'd0, found}, 32'd1);
    rst_drv = 1'b1; pat_sel = 7;
    repeat (3) step();
    rst_drv = 1'b0;
    repeat (27 * FRAME) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
